// File: rtl/example_fig_8_9_str_pkg.sv
// Shared definitions for the fig 8.9 ASM controller/datapath pair:
// state encoding and the 4-bit ripple incrementer used by the datapath.
package example_fig_8_9_str_pkg;

  localparam int A_W = 4;

  // State codes are fixed; 2'b10 is unused and decodes back to idle.
  typedef enum logic [1:0] {
    S_idle = 2'b00,
    S_1    = 2'b01,
    S_2    = 2'b11
  } state_t;

  // Gate-level style ripple incrementer (a + 1, modulo 16).
  function automatic logic [A_W-1:0] incr4(input logic [A_W-1:0] a);
    logic [A_W-1:0] sum;
    logic           carry;
    carry = 1'b1;
    for (int i = 0; i < A_W; i++) begin
      sum[i] = a[i] ^ carry;
      carry  = a[i] & carry;
    end
    return sum;
  endfunction

endpackage

// File: rtl/fig_8_9_control.sv
// Controller for the fig 8.9 ASM chart: state register plus decode of the
// datapath control strobes from state, Start, A[2] and A[3].
module fig_8_9_control
  import example_fig_8_9_str_pkg::*;
(
  input  logic clock,
  input  logic reset_b,
  input  logic Start,
  input  logic A2,
  input  logic A3,
  output logic clr_A_F,
  output logic incr_A,
  output logic set_E,
  output logic clr_E,
  output logic set_F
);

  state_t r_state;
  state_t w_next;

  // State register; synchronous active-low reset forces idle.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_state <= S_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode; all decisions use the pre-increment A.
  always_comb begin
    w_next  = S_idle;
    clr_A_F = 1'b0;
    incr_A  = 1'b0;
    set_E   = 1'b0;
    clr_E   = 1'b0;
    set_F   = 1'b0;
    case (r_state)
      S_idle: begin
        if (Start) begin
          clr_A_F = 1'b1;
          w_next  = S_1;
        end else begin
          w_next  = S_idle;
        end
      end
      S_1: begin
        incr_A = 1'b1;
        set_E  = A2;
        clr_E  = ~A2;
        w_next = (A2 & A3) ? S_2 : S_1;
      end
      S_2: begin
        set_F  = 1'b1;
        w_next = S_idle;
      end
      default: begin
        // Unused code 2'b10: recover to idle with no datapath action.
        w_next = S_idle;
      end
    endcase
  end

endmodule

// File: rtl/fig_8_9_datapath.sv
// Datapath for the fig 8.9 ASM chart: counter A and flags E, F, each a
// D flip-flop bank fed by next-state logic driven from the control strobes.
module fig_8_9_datapath
  import example_fig_8_9_str_pkg::*;
(
  input  logic           clock,
  input  logic           reset_b,
  input  logic           clr_A_F,
  input  logic           incr_A,
  input  logic           set_E,
  input  logic           clr_E,
  input  logic           set_F,
  output logic [A_W-1:0] A,
  output logic           E,
  output logic           F
);

  logic [A_W-1:0] r_A;
  logic           r_E;
  logic           r_F;
  logic [A_W-1:0] w_A_inc;
  logic [A_W-1:0] w_A_d;
  logic           w_E_d;
  logic           w_F_d;

  assign w_A_inc = incr4(r_A);

  // D inputs: at most one strobe per register is active in any cycle.
  always_comb begin
    w_A_d = r_A;
    w_E_d = r_E;
    w_F_d = r_F;
    if (clr_A_F) begin
      w_A_d = '0;
      w_F_d = 1'b0;
    end else begin
      if (incr_A) w_A_d = w_A_inc;
      if (set_F)  w_F_d = 1'b1;
    end
    if (set_E)      w_E_d = 1'b1;
    else if (clr_E) w_E_d = 1'b0;
  end

  // Register bank; reset clears all three registers.
  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_A <= '0;
      r_E <= 1'b0;
      r_F <= 1'b0;
    end else begin
      r_A <= w_A_d;
      r_E <= w_E_d;
      r_F <= w_F_d;
    end
  end

  assign A = r_A;
  assign E = r_E;
  assign F = r_F;

endmodule

// File: rtl/example_fig_8_9_str.sv
// Structural top for the fig 8.9 ASM design: wires controller to datapath.
module example_fig_8_9_str
  import example_fig_8_9_str_pkg::*;
(
  output logic [A_W-1:0] A,
  output logic           E,
  output logic           F,
  input  logic           Start,
  input  logic           clock,
  input  logic           reset_b
);

  logic w_clr_A_F;
  logic w_incr_A;
  logic w_set_E;
  logic w_clr_E;
  logic w_set_F;

  fig_8_9_control u_control (
    .clock   (clock),
    .reset_b (reset_b),
    .Start   (Start),
    .A2      (A[2]),
    .A3      (A[3]),
    .clr_A_F (w_clr_A_F),
    .incr_A  (w_incr_A),
    .set_E   (w_set_E),
    .clr_E   (w_clr_E),
    .set_F   (w_set_F)
  );

  fig_8_9_datapath u_datapath (
    .clock   (clock),
    .reset_b (reset_b),
    .clr_A_F (w_clr_A_F),
    .incr_A  (w_incr_A),
    .set_E   (w_set_E),
    .clr_E   (w_clr_E),
    .set_F   (w_set_F),
    .A       (A),
    .E       (E),
    .F       (F)
  );

endmodule

// File: tb/tb_example_fig_8_9_str.sv
// Directed bench for example_fig_8_9_str with hand-computed expectations.
module tb_example_fig_8_9_str;

  logic [3:0] A;
  logic       E;
  logic       F;
  logic       Start;
  logic       clock;
  logic       reset_b;

  int errors = 0;
  int checks = 0;

  example_fig_8_9_str dut (
    .A       (A),
    .E       (E),
    .F       (F),
    .Start   (Start),
    .clock   (clock),
    .reset_b (reset_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle outputs before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_aef(input string tag, input logic [3:0] ea, input logic ee, input logic ef);
    check({tag, ".A"}, A, ea);
    check({tag, ".E"}, {3'b0, E}, {3'b0, ee});
    check({tag, ".F"}, {3'b0, F}, {3'b0, ef});
  endtask

  initial begin
    logic [3:0] pre;
    Start   = 1'b0;
    reset_b = 1'b0;

    // Reset
    step();
    check_aef("reset", 4'd0, 1'b0, 1'b0);
    reset_b = 1'b1;
    step();
    step();
    check_aef("idle_hold", 4'd0, 1'b0, 1'b0);

    // Run 1: single-edge Start pulse
    Start = 1'b1;
    step();
    check_aef("run1_e0", 4'd0, 1'b0, 1'b0);
    Start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      pre = 4'(k - 1);
      check_aef($sformatf("run1_e%0d", k), 4'(k), pre[2], 1'b0);
    end
    step();
    check_aef("run1_e14", 4'd13, 1'b1, 1'b1);
    step();
    step();
    check_aef("run1_idle", 4'd13, 1'b1, 1'b1);

    // Run 2: E=1 left over, Start pulsed again mid-run (ignored)
    Start = 1'b1;
    step();
    check_aef("run2_e0", 4'd0, 1'b1, 1'b0);
    Start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      Start = (k == 3 || k == 9);
      step();
      Start = 1'b0;
      pre = 4'(k - 1);
      check_aef($sformatf("run2_e%0d", k), 4'(k), pre[2], 1'b0);
    end
    step();
    check_aef("run2_e14", 4'd13, 1'b1, 1'b1);
    step();
    check_aef("run2_idle", 4'd13, 1'b1, 1'b1);

    // Reset mid-run at A=6
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    check_aef("mid_A6", 4'd6, 1'b1, 1'b0);
    reset_b = 1'b0;
    step();
    reset_b = 1'b1;
    check_aef("mid_reset", 4'd0, 1'b0, 1'b0);
    step();
    step();
    step();
    check_aef("post_reset_idle", 4'd0, 1'b0, 1'b0);

    // Start held high: new run launches right after S_2
    Start = 1'b1;
    step();
    check_aef("held_e0", 4'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) step();
    check_aef("held_e13", 4'd13, 1'b1, 1'b0);
    step();
    check_aef("held_e14", 4'd13, 1'b1, 1'b1);
    step();
    check_aef("held_e15", 4'd0, 1'b1, 1'b0);
    step();
    check_aef("held_e16", 4'd1, 1'b0, 1'b0);
    Start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog bounds the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
